// File: rtl/long_op_wb_arbiter_pkg.sv
// Shared types and constants for the long-latency writeback arbiter.
// Requester slots, the default RF geometry and the round-robin helper live here.
package long_op_wb_arbiter_pkg;

  localparam int unsigned RV32_reg_els_gp    = 32;
  localparam int unsigned long_op_num_req_gp = 3;

  typedef enum logic [1:0] {
    LONG_OP_REMOTE_LOAD = 2'd0,
    LONG_OP_IDIV        = 2'd1,
    LONG_OP_FDIV_SQRT   = 2'd2
  } long_op_req_e;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
  } long_op_wb_req_s;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/long_op_wb_arbiter_rr.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves just past the winner when the grant is consumed (yumi_i).
module long_op_wb_arbiter_rr
  import long_op_wb_arbiter_pkg::*;
#(
  parameter int unsigned num_req_p = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  input  logic [num_req_p-1:0] reqs_i,
  output logic [num_req_p-1:0] grants_o,
  output logic                 v_o,
  input  logic                 yumi_i
);

  localparam int unsigned ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [ptr_w_lp-1:0] ptr_q, ptr_d;
  logic [ptr_w_lp-1:0] winner;
  logic                found;

  // Two passes over constant indices: first from the pointer upward, then the wrap.
  always_comb begin
    grants_o = '0;
    winner   = ptr_q;
    found    = 1'b0;
    for (int unsigned j = 0; j < num_req_p; j++) begin
      if (en_i && !found && reqs_i[j] && (j >= 32'(ptr_q))) begin
        found       = 1'b1;
        grants_o[j] = 1'b1;
        winner      = ptr_w_lp'(j);
      end
    end
    for (int unsigned j = 0; j < num_req_p; j++) begin
      if (en_i && !found && reqs_i[j] && (j < 32'(ptr_q))) begin
        found       = 1'b1;
        grants_o[j] = 1'b1;
        winner      = ptr_w_lp'(j);
      end
    end
    v_o   = found;
    ptr_d = ptr_w_lp'(rr_next(32'(winner), num_req_p));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else if (yumi_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/long_op_wb_arbiter.sv
// Shares the RF write port and scoreboard clear among long-latency producers.
// One-entry buffer per requester, round-robin pick, pipeline priority with starvation stall.
module long_op_wb_arbiter
  import long_op_wb_arbiter_pkg::*;
#(
  parameter  int unsigned num_req_p         = long_op_num_req_gp,
  parameter  int unsigned data_width_p      = 32,
  parameter  int unsigned reg_els_p         = RV32_reg_els_gp,
  parameter  int unsigned x0_tied_to_zero_p = 1,
  parameter  int unsigned starve_limit_p    = 4,
  localparam int unsigned id_width_lp       = $clog2(reg_els_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              v_i,
  input  logic [num_req_p*id_width_lp-1:0]  id_i,
  input  logic [num_req_p*data_width_p-1:0] data_i,
  output logic [num_req_p-1:0]              ready_o,
  input  logic                              pipe_wb_v_i,
  output logic                              pipe_stall_o,
  output logic                              rf_wb_v_o,
  output logic [id_width_lp-1:0]            rf_wb_id_o,
  output logic [data_width_p-1:0]           rf_wb_data_o,
  output logic                              clear_o,
  output logic [id_width_lp-1:0]            clear_id_o
);

  localparam int unsigned cnt_w_lp = $clog2(starve_limit_p + 1);

  typedef struct packed {
    logic [id_width_lp-1:0]  id;
    logic [data_width_p-1:0] data;
  } wb_req_t;

  wb_req_t                buf_q [num_req_p];
  logic [num_req_p-1:0]   buf_v_q;
  logic [num_req_p-1:0]   grant;
  logic [num_req_p-1:0]   load;
  logic                   grant_v;
  wb_req_t                sel;
  logic                   drop;

  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic                   stall_q, stall_d;
  logic                   rf_wb_v_q;
  logic [id_width_lp-1:0] rf_wb_id_q;
  logic [data_width_p-1:0] rf_wb_data_q;

  long_op_wb_arbiter_rr #(
    .num_req_p(num_req_p)
  ) arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (~pipe_wb_v_i),
    .reqs_i    (buf_v_q),
    .grants_o  (grant),
    .v_o       (grant_v),
    .yumi_i    (grant_v)
  );

  assign ready_o = ~buf_v_q | grant;
  assign load    = v_i & ready_o;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grant[i]) sel = sel | buf_q[i];
    end
    drop = (x0_tied_to_zero_p != 0) && (sel.id == '0);
  end

  // A blocked run reaching the limit raises the stall and restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    if (grant_v || !(|buf_v_q)) begin
      cnt_d = '0;
    end else if (pipe_wb_v_i) begin
      if (cnt_q >= cnt_w_lp'(starve_limit_p - 1)) begin
        cnt_d   = '0;
        stall_d = 1'b1;
      end else begin
        cnt_d = cnt_q + cnt_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      buf_v_q      <= '0;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      rf_wb_v_q    <= 1'b0;
      rf_wb_id_q   <= '0;
      rf_wb_data_q <= '0;
    end else begin
      buf_v_q   <= load | (buf_v_q & ~grant);
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      rf_wb_v_q <= grant_v & ~drop;
      if (grant_v) begin
        rf_wb_id_q   <= sel.id;
        rf_wb_data_q <= sel.data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (load[i]) begin
        buf_q[i].id   <= id_i[i*id_width_lp +: id_width_lp];
        buf_q[i].data <= data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  assign pipe_stall_o = stall_q;
  assign rf_wb_v_o    = rf_wb_v_q;
  assign rf_wb_id_o   = rf_wb_id_q;
  assign rf_wb_data_o = rf_wb_data_q;
  assign clear_o      = rf_wb_v_q;
  assign clear_id_o   = rf_wb_id_q;

  logic dup_id;
  always_comb begin
    dup_id = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      for (int unsigned j = i + 1; j < num_req_p; j++) begin
        if (buf_v_q[i] && buf_v_q[j] && (buf_q[i].id == buf_q[j].id) && (buf_q[i].id != '0))
          dup_id = 1'b1;
      end
    end
  end

  a_stall_no_pipe_wb: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    stall_q |-> !pipe_wb_v_i);
  a_unique_ids: assert property (@(posedge clk_i) disable iff (!reset_n_i) !dup_id);

endmodule

// File: tb/tb_long_op_wb_arbiter.sv
// Directed and random checks of the writeback arbiter against a cycle-level reference model.
module tb_long_op_wb_arbiter;

  localparam int unsigned N     = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDW   = 5;
  localparam int unsigned LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      v_i;
  logic [N*IDW-1:0]  id_i;
  logic [N*DW-1:0]   data_i;
  logic [N-1:0]      ready_o;
  logic              pipe_wb_v_i;
  logic              pipe_stall_o;
  logic              rf_wb_v_o;
  logic [IDW-1:0]    rf_wb_id_o;
  logic [DW-1:0]     rf_wb_data_o;
  logic              clear_o;
  logic [IDW-1:0]    clear_id_o;

  long_op_wb_arbiter #(
    .num_req_p(N), .data_width_p(DW), .reg_els_p(32),
    .x0_tied_to_zero_p(1), .starve_limit_p(LIMIT)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .id_i(id_i), .data_i(data_i),
    .ready_o(ready_o), .pipe_wb_v_i(pipe_wb_v_i), .pipe_stall_o(pipe_stall_o),
    .rf_wb_v_o(rf_wb_v_o), .rf_wb_id_o(rf_wb_id_o), .rf_wb_data_o(rf_wb_data_o),
    .clear_o(clear_o), .clear_id_o(clear_id_o)
  );

  always #5 clk = ~clk;

  // reference model state
  bit          m_bv [N];
  int          m_bid [N];
  logic [31:0] m_bdata [N];
  int          m_ptr, m_run;
  bit          m_stall, m_wv;
  int          m_wid;
  logic [31:0] m_wdata;

  // stimulus for the next step
  bit          d_v [N];
  int          d_id [N];
  logic [31:0] d_data [N];
  bit          want_pipe;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int wq[$];
  int wcyc[$];
  int stall_seen;
  int stall_cyc;
  int s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 0; m_bid[i] = 0; m_bdata[i] = '0; d_v[i] = 0;
    end
    m_ptr = 0; m_run = 0; m_stall = 0; m_wv = 0; m_wid = 0; m_wdata = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wb_v"}, rf_wb_v_o, 0);
    check({tag, "_clear"}, clear_o, 0);
    check({tag, "_stall"}, pipe_stall_o, 0);
    check({tag, "_wb_id"}, rf_wb_id_o, 0);
    check({tag, "_wb_data"}, rf_wb_data_o, 0);
    check({tag, "_ready"}, ready_o, 3'b111);
  endtask

  task automatic step();
    int g;
    int j;
    bit anyv;
    bit pipe;
    logic [N-1:0] rdy;
    @(negedge clk);
    cyc++;
    check("rf_wb_v", rf_wb_v_o, m_wv);
    check("clear_v", clear_o, m_wv);
    check("stall", pipe_stall_o, m_stall);
    if (m_wv) begin
      check("rf_wb_id", rf_wb_id_o, m_wid);
      check("clear_id", clear_id_o, m_wid);
      check("rf_wb_data", rf_wb_data_o, m_wdata);
    end
    if (rf_wb_v_o) begin wq.push_back(int'(rf_wb_id_o)); wcyc.push_back(cyc); end
    if (pipe_stall_o) begin stall_seen++; stall_cyc = cyc; end
    pipe = want_pipe && !m_stall;
    pipe_wb_v_i = pipe;
    for (int i = 0; i < N; i++) begin
      v_i[i] = d_v[i];
      id_i[i*IDW +: IDW] = d_id[i][IDW-1:0];
      data_i[i*DW +: DW] = d_data[i];
    end
    #1;
    g = -1;
    if (!pipe) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && m_bv[j]) g = j;
      end
    end
    anyv = 0;
    for (int i = 0; i < N; i++) begin
      rdy[i] = !m_bv[i] || (g == i);
      if (m_bv[i]) anyv = 1;
    end
    check("ready", ready_o, rdy);
    m_wv = (g >= 0) && (m_bid[g] != 0);
    if (g >= 0) begin
      m_wid = m_bid[g]; m_wdata = m_bdata[g]; m_ptr = (g + 1) % N;
    end
    if (g >= 0 || !anyv) begin
      m_run = 0; m_stall = 0;
    end else begin
      m_run++;
      m_stall = (m_run == LIMIT);
      if (m_stall) m_run = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (d_v[i] && rdy[i]) begin
        m_bv[i] = 1; m_bid[i] = d_id[i]; m_bdata[i] = d_data[i];
      end else if (g == i) begin
        m_bv[i] = 0;
      end
      d_v[i] = 0;
    end
  endtask

  task automatic send(input int r, input int id, input logic [31:0] data);
    d_v[r] = 1; d_id[r] = id; d_data[r] = data;
  endtask

  function automatic int pick_id(input int self);
    int c;
    bit ok;
    c = 1;
    for (int t = 0; t < 200; t++) begin
      c = int'($urandom_range(1, 31));
      ok = 1;
      for (int j = 0; j < N; j++) begin
        if (m_bv[j] && m_bid[j] == c) ok = 0;
        if (j != self && d_v[j] && d_id[j] == c) ok = 0;
      end
      if (ok) break;
    end
    return c;
  endfunction

  task automatic check_order(input string tag, input int e0, input int e1, input int e2);
    int exp_ids [3];
    exp_ids = '{e0, e1, e2};
    check({tag, "_count"}, wq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < wq.size()) check({tag, "_id"}, wq[k], exp_ids[k]);
      if (k > 0 && k < wq.size()) check({tag, "_gap"}, wcyc[k] - wcyc[k-1], 1);
    end
  endtask

  initial begin
    reset_n = 0; v_i = '0; id_i = '0; data_i = '0; pipe_wb_v_i = 0; want_pipe = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    reset_n = 1;

    // burst from all requesters with the pointer at 0, then a wrapped repeat
    wq.delete(); wcyc.delete();
    send(0, 3, 32'h0000_0303); send(1, 4, 32'h0000_0404); send(2, 6, 32'h0000_0606);
    step(); repeat (5) step();
    check_order("burst1", 3, 4, 6);
    wq.delete(); wcyc.delete();
    send(0, 10, $urandom); send(1, 11, $urandom); send(2, 12, $urandom);
    step(); repeat (5) step();
    check_order("burst2", 10, 11, 12);
    send(1, 9, $urandom);
    step(); repeat (3) step();
    wq.delete(); wcyc.delete();
    send(0, 13, $urandom); send(1, 14, $urandom); send(2, 15, $urandom);
    step(); repeat (5) step();
    check_order("rotate", 15, 13, 14);

    // single writeback latency
    wq.delete(); wcyc.delete();
    send(0, 5, 32'hA5A5_A5A5);
    step(); s = cyc;
    repeat (4) step();
    check("lat_count", wq.size(), 1);
    if (wq.size() > 0) begin
      check("lat_id", wq[0], 5);
      check("lat_cycle", wcyc[0], s + 2);
    end

    // starvation: pipe owns the port continuously
    wq.delete(); wcyc.delete(); stall_seen = 0; stall_cyc = 0;
    want_pipe = 1;
    send(1, 7, 32'h0000_0077);
    step(); s = cyc;
    repeat (10) step();
    want_pipe = 0;
    step();
    check("starve_pulses", stall_seen, 1);
    check("starve_stall_cycle", stall_cyc, s + LIMIT + 1);
    check("starve_count", wq.size(), 1);
    if (wq.size() > 0) begin
      check("starve_id", wq[0], 7);
      check("starve_wb_cycle", wcyc[0], s + LIMIT + 2);
    end

    // writeback to x0 is consumed silently
    wq.delete(); wcyc.delete();
    send(2, 0, 32'hDEAD_BEEF);
    step(); repeat (4) step();
    check("x0_writes", wq.size(), 0);
    check("x0_ready", ready_o, 3'b111);

    // back-to-back stream from one requester
    wq.delete(); wcyc.delete();
    for (int k = 1; k <= 8; k++) begin
      send(0, k, 32'h1000_0000 + k);
      step();
    end
    repeat (3) step();
    check("stream_count", wq.size(), 8);
    for (int k = 0; k < 8 && k < wq.size(); k++) begin
      check("stream_id", wq[k], k + 1);
      if (k > 0) check("stream_gap", wcyc[k] - wcyc[k-1], 1);
    end

    // reset while a write is visible and another buffer is still held
    send(0, 20, $urandom); send(1, 21, $urandom);
    step();
    step();
    @(negedge clk);
    cyc++;
    check("prerst_wb_v", rf_wb_v_o, m_wv);
    check("prerst_wb_id", rf_wb_id_o, m_wid);
    #2 reset_n = 0;
    #1 check_idle_outputs("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    wq.delete(); wcyc.delete();
    repeat (6) step();
    check("postrst_writes", wq.size(), 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      want_pipe = ($urandom_range(0, 99) < 65);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 40) begin
          d_v[i]    = 1;
          d_id[i]   = ($urandom_range(0, 9) == 0) ? 0 : pick_id(i);
          d_data[i] = $urandom;
        end
      end
      step();
    end
    want_pipe = 0;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
